// File: rtl/i4_operand_loader.sv
// Operand loader for the i4 AND-OR cone: it packs a stream of narrow words
// into one PI_W-bit frame and holds the frame until downstream acks it.
module i4_operand_loader #(
  parameter int PI_W   = 192,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  output logic [PI_W-1:0]   pi_bus,
  output logic              pi_valid,
  input  logic              pi_ack,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_count
);

  localparam int NUM_WORDS = PI_W / WORD_W;
  localparam int SLOT_W =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT =
    SLOT_W'(NUM_WORDS - 1);

  if ((PI_W % WORD_W) != 0) begin : g_bad_width
    $error("PI_W must be a multiple of WORD_W");
  end

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    PRESENT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [PI_W-1:0]   bus_q, bus_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    bus_d   = bus_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      FILL: begin
        if (in_valid) begin
          for (int i = 0; i < NUM_WORDS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
              bus_d[i*WORD_W +: WORD_W] = in_data;
            end
          end
          if (slot_q == LAST_SLOT) begin
            slot_d = '0;
            if (in_last) begin
              state_d = PRESENT;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (in_last) begin
            err_d  = 1'b1;
            slot_d = '0;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
      end
      PRESENT: begin
        if (pi_ack) begin
          state_d = FILL;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // Swallow the tail of an overlong frame.
        if (in_valid && in_last) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FILL;
      slot_q  <= '0;
      bus_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      bus_q   <= bus_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = !reset && (state_q != PRESENT);
  assign pi_valid    = (state_q == PRESENT);
  assign pi_bus      = bus_q;
  assign frame_err   = err_q;
  assign frame_count = cnt_q;

endmodule

// File: tb/tb_i4_operand_loader.sv
// Scoreboard bench for i4_operand_loader: frames queued on send,
// popped and compared on each pi_valid/pi_ack handshake.
module tb_i4_operand_loader;

  localparam int PI_W   = 192;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 8;
  localparam int NW     = PI_W / WORD_W;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [WORD_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [PI_W-1:0]   pi_bus;
  logic              pi_valid;
  logic              pi_ack = 1'b0;
  logic              frame_err;
  logic [CNT_W-1:0]  frame_count;

  int n_chk = 0;
  int n_bad = 0;
  int exp_err = 0;
  int err_seen = 0;
  int ack_mode = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [PI_W-1:0]  sb_q[$];

  i4_operand_loader #(
    .PI_W(PI_W), .WORD_W(WORD_W), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_last(in_last),
    .pi_bus(pi_bus), .pi_valid(pi_valid),
    .pi_ack(pi_ack), .frame_err(frame_err),
    .frame_count(frame_count)
  );

  always #5 clock = ~clock;

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [PI_W-1:0] got,
                     input logic [PI_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clock) begin
    #1;
    case (ack_mode)
      1:       pi_ack = 1'($urandom_range(0, 1));
      2:       pi_ack = 1'b1;
      default: pi_ack = 1'b0;
    endcase
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (frame_err) begin
        err_seen++;
        chk("err_in_present", pi_valid, 0);
      end
      if (pi_valid && pi_ack) begin
        chk("count", frame_count, exp_cnt);
        if (sb_q.size() == 0) begin
          chk("unexpected_frame", 1, 0);
        end else begin
          chk("frame", pi_bus, sb_q.pop_front());
        end
        exp_cnt = exp_cnt + 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset    = 1'b1;
    ack_mode = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_valid", pi_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_cnt", frame_count, 0);
    chk("rst_bus", pi_bus, 0);
    sb_q.delete();
    exp_cnt = '0;
    reset   = 1'b0;
  endtask

  task automatic put_word(input logic [WORD_W-1:0] d,
                          input bit last, input bit bub);
    int t;
    if (bub) begin
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    t = 0;
    @(negedge clock);
    while (!in_ready && t < 1000) begin
      @(negedge clock);
      t++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [PI_W-1:0] f,
                            input int n, input bit bub);
    if (n == NW) sb_q.push_back(f);
    else exp_err++;
    for (int i = 0; i < n; i++) begin
      put_word(f[(i % NW)*WORD_W +: WORD_W], i == n-1, bub);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 5000) begin
      @(posedge clock);
      t++;
    end
    chk("drain", sb_q.size(), 0);
    repeat (2) @(posedge clock);
    #1;
    ack_mode = 0;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [PI_W-1:0] rnd_frame();
    logic [PI_W-1:0] f;
    for (int i = 0; i < PI_W/32; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  initial begin
    logic [PI_W-1:0] f;
    int t;
    do_reset();

    // T1: counting frame, held without ack
    for (int i = 0; i < NW; i++) f[i*WORD_W +: WORD_W] = WORD_W'(i+1);
    send_frame(f, NW, 0);
    chk("t1_valid", pi_valid, 1);
    chk("t1_lo", pi_bus[15:0], 16'h0001);
    chk("t1_hi", pi_bus[191:176], 16'h000C);
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clock);
      chk("t1_hold", pi_bus, f);
      chk("t1_ready", in_ready, 0);
    end
    in_valid = 1'b0;

    // T5a: reset while presenting
    do_reset();

    // T2: all-ones, then ack
    send_frame('1, NW, 0);
    chk("t2_valid", pi_valid, 1);
    ack_mode = 2;
    t = 0;
    @(negedge clock);
    while (!pi_ack && t < 10) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #2;
    chk("t2_valid_drop", pi_valid, 0);
    chk("t2_count", frame_count, 1);
    chk("t2_ready", in_ready, 1);
    ack_mode = 0;

    // T3: short frame, then clean frame
    send_frame(rnd_frame(), 5, 0);
    chk("t3_err", frame_err, 1);
    chk("t3_novalid", pi_valid, 0);
    @(posedge clock);
    #1;
    chk("t3_err_pulse", frame_err, 0);
    ack_mode = 2;
    send_frame(rnd_frame(), NW, 1);
    wait_drain();

    // T4: 14-word frame, then clean frame
    f = rnd_frame();
    exp_err++;
    for (int i = 0; i < NW; i++) put_word(f[i*WORD_W +: WORD_W], 0, 0);
    chk("t4_err", frame_err, 1);
    chk("t4_novalid", pi_valid, 0);
    put_word(16'hDEAD, 0, 0);
    chk("t4_err_pulse", frame_err, 0);
    put_word(16'hBEEF, 1, 0);
    chk("t4_bus_kept", pi_bus, f);
    chk("t4_novalid2", pi_valid, 0);
    ack_mode = 2;
    send_frame(rnd_frame(), NW, 1);
    wait_drain();

    // T5b: reset mid-fill, then clean frame from slot 0
    f = rnd_frame();
    for (int i = 0; i < 7; i++) put_word(f[i*WORD_W +: WORD_W], 0, 0);
    do_reset();
    ack_mode = 2;
    send_frame(rnd_frame(), NW, 0);
    wait_drain();

    // T6: random backpressure, count wraps
    do_reset();
    ack_mode = 1;
    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      send_frame(rnd_frame(), NW, 1);
    end
    wait_drain();
    chk("t6_wrap", frame_count, 3);
    chk("err_total", err_seen, exp_err);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
